lcd_text_engine: RTL and testbench

LCD_TEXT_ENGINE -- requirements
Module: lcd_text_engine

---
 rtl/lcd_text_engine.sv | 179 +++++++++++++++++
 tb/tb_lcd_text_engine.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_engine.sv
// Character-LCD refresh engine: register text buffer, HD44780-style init,
// then endless line-address + character writes with fixed bus timing.
module lcd_text_engine #(
  parameter int LINES = 2,
  parameter int COLS = 16,
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC = 16,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int PWR_WAIT_CYC = 750000,
  parameter bit BLON = 1'b1,
  localparam int N = LINES * COLS,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          CLOCK_50,
  input  logic          RST_N,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          init_done,
  output logic          frame_done,
  output logic          LCD_ON,
  output logic          LCD_BLON,
  output logic          LCD_RW,
  output logic          LCD_EN,
  output logic          LCD_RS,
  inout  wire  [7:0]    LCD_DATA
);

  localparam int T_CMD = SETUP_CYC + EN_CYC + CMD_WAIT_CYC;
  localparam int T_CLR = SETUP_CYC + EN_CYC + CLR_WAIT_CYC;
  localparam int T_MAX = (PWR_WAIT_CYC > T_CLR) ? PWR_WAIT_CYC : T_CLR;
  localparam int CW = $clog2(T_MAX + 1);
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [CW-1:0] PWR_LAST = CW'(PWR_WAIT_CYC - 1);
  localparam logic [CW-1:0] EN_ON = CW'(SETUP_CYC);
  localparam logic [CW-1:0] EN_OFF = CW'(SETUP_CYC + EN_CYC);
  localparam logic [CW-1:0] CMD_LAST = CW'(T_CMD - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(T_CLR - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(COLS - 1);
  localparam logic LINE_LAST = 1'(LINES - 1);
  localparam logic EN_AT0 = (SETUP_CYC == 0);
  localparam logic [7:0] FUNC_SET = (LINES == 2) ? 8'h38 : 8'h30;

  typedef enum logic [1:0] {
    PWR_WAIT, INIT, LINE_ADDR, CHAR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    step;
  logic          line;
  logic [CLW-1:0] col;
  logic          en_q;
  logic          rs_q;
  logic [7:0]    data_q;
  logic          init_q;
  logic          fd_q;
  logic [7:0]    chars [N];

  logic [CW-1:0] cnt_n;
  logic [CW-1:0] t_last;
  logic          last;
  logic          final_char;
  logic          next_line;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_byte;

  function automatic logic [7:0] init_cmd(input logic [1:0] s);
    case (s)
      2'd0:    init_cmd = FUNC_SET;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  always_comb begin
    cnt_n = cnt + CW'(1);
    t_last = (!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST;
    last = (cnt == t_last);
    final_char = (col == COL_LAST) && (line == LINE_LAST);
    next_line = (line == LINE_LAST) ? 1'b0 : 1'b1;
    rd_addr = (state == CHAR)
      ? AW'(int'(line) * COLS + int'(col) + 1)
      : AW'(int'(line) * COLS);
    rd_byte = chars[rd_addr];
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N; i++) chars[i] <= 8'h20;
    end else if (wr_en && int'(wr_addr) < N) begin
      chars[wr_addr] <= wr_data;
    end
  end

  // The next transaction launches on the edge that ends the current one,
  // so the buffer byte is latched from the pre-write contents.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state <= PWR_WAIT;
      cnt <= '0;
      step <= '0;
      line <= 1'b0;
      col <= '0;
      en_q <= 1'b0;
      rs_q <= 1'b0;
      data_q <= 8'h00;
      init_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if (state == PWR_WAIT) begin
        if (cnt == PWR_LAST) begin
          state <= INIT;
          step <= 2'd0;
          cnt <= '0;
          en_q <= EN_AT0;
          rs_q <= 1'b0;
          data_q <= init_cmd(2'd0);
        end else begin
          cnt <= cnt_n;
        end
      end else if (!last) begin
        cnt <= cnt_n;
        en_q <= (cnt_n >= EN_ON) && (cnt_n < EN_OFF);
        fd_q <= (state == CHAR) && final_char && (cnt_n == t_last);
      end else begin
        cnt <= '0;
        en_q <= EN_AT0;
        case (state)
          INIT: begin
            rs_q <= 1'b0;
            if (step == 2'd3) begin
              init_q <= 1'b1;
              state <= LINE_ADDR;
              line <= 1'b0;
              data_q <= 8'h80;
            end else begin
              step <= step + 2'd1;
              data_q <= init_cmd(step + 2'd1);
            end
          end
          LINE_ADDR: begin
            state <= CHAR;
            col <= '0;
            rs_q <= 1'b1;
            data_q <= rd_byte;
          end
          CHAR: begin
            if (col == COL_LAST) begin
              state <= LINE_ADDR;
              line <= next_line;
              rs_q <= 1'b0;
              data_q <= {1'b1, next_line, 6'd0};
            end else begin
              col <= col + CLW'(1);
              rs_q <= 1'b1;
              data_q <= rd_byte;
            end
          end
          default: state <= PWR_WAIT;
        endcase
      end
    end
  end

  assign init_done = init_q;
  assign frame_done = fd_q;
  assign LCD_ON = 1'b1;
  assign LCD_BLON = BLON;
  assign LCD_RW = 1'b0;
  assign LCD_EN = en_q;
  assign LCD_RS = rs_q;
  assign LCD_DATA = data_q;

endmodule

// File: tb/tb_lcd_text_engine.sv
// Bench for lcd_text_engine: bus scoreboard, timing monitor,
// same-cycle write, out-of-range write and mid-transaction reset.
module tb_lcd_text_engine;

  typedef struct {
    int         addr;
    logic [7:0] data;
    bit         lands;
  } wr_rec_t;

  typedef struct {
    logic [7:0] cmd;
    int         wait_cyc;
  } init_rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic init_done, frame_done, lcd_on, lcd_blon, lcd_rw, lcd_en, lcd_rs;
  wire  [7:0] lcd_data;

  logic       b_wr_en;
  logic [5:0] b_wr_addr;
  logic [7:0] b_wr_data;
  logic b_init_done, b_frame_done, b_on, b_blon, b_rw, b_en, b_rs;
  wire  [7:0] b_data;

  lcd_text_engine #(
    .LINES(2), .COLS(16), .SETUP_CYC(1), .EN_CYC(2),
    .CMD_WAIT_CYC(4), .CLR_WAIT_CYC(10), .PWR_WAIT_CYC(20), .BLON(1'b1)
  ) dut (
    .CLOCK_50(clk), .RST_N(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_done(init_done), .frame_done(frame_done),
    .LCD_ON(lcd_on), .LCD_BLON(lcd_blon), .LCD_RW(lcd_rw),
    .LCD_EN(lcd_en), .LCD_RS(lcd_rs), .LCD_DATA(lcd_data)
  );

  // 40-entry instance so that address 40 is representable on the port
  lcd_text_engine #(
    .LINES(2), .COLS(20), .SETUP_CYC(1), .EN_CYC(2),
    .CMD_WAIT_CYC(4), .CLR_WAIT_CYC(10), .PWR_WAIT_CYC(20), .BLON(1'b1)
  ) dut_b (
    .CLOCK_50(clk), .RST_N(rst_n),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .init_done(b_init_done), .frame_done(b_frame_done),
    .LCD_ON(b_on), .LCD_BLON(b_blon), .LCD_RW(b_rw),
    .LCD_EN(b_en), .LCD_RS(b_rs), .LCD_DATA(b_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic int wait_of(input logic [8:0] b);
    return (b == 9'h001) ? 10 : 4;
  endfunction

  logic [8:0] exp_q [$];
  logic [7:0] model [32];
  bit chk_on = 1'b0;

  task automatic push_frame();
    for (int l = 0; l < 2; l++) begin
      exp_q.push_back({1'b0, (l == 1) ? 8'hC0 : 8'h80});
      for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, model[l * 16 + c]});
    end
  endtask

  // main-instance monitor
  int cyc, rise_cyc, fall_cyc, change_cyc, last_data_rise;
  int data_rises = 0;
  int chars_in_frame, frames = 0;
  bit pen, pfd, pinit, have_prev, seen80;
  logic [8:0] pbus, prev_byte, bus, e;

  always @(posedge clk) cyc = rst_n ? cyc + 1 : 0;

  always @(negedge clk) begin
    bus = {lcd_rs, lcd_data};
    if (!rst_n) begin
      pen = 1'b0; pfd = 1'b0; pinit = 1'b0; have_prev = 1'b0; seen80 = 1'b0;
      rise_cyc = 0; fall_cyc = 0; change_cyc = 0; last_data_rise = 0;
      chars_in_frame = 0; pbus = bus;
    end else begin
      if (bus != pbus) begin
        change_cyc = cyc;
        if (have_prev) chk("gap", cyc - fall_cyc, wait_of(prev_byte));
      end
      if (lcd_en && !pen) begin
        if (!have_prev) chk("pwr_wait", cyc, 21);
        else chk("rise_to_rise", cyc - rise_cyc, 3 + wait_of(prev_byte));
        if (!have_prev || change_cyc > fall_cyc) chk("setup", cyc - change_cyc, 1);
        rise_cyc = cyc;
        if (bus == 9'h080) seen80 = 1'b1;
        chk("init_done", int'(init_done), int'(seen80));
        if (chk_on) begin
          if (exp_q.size() == 0) fail("unexpected_txn");
          else begin
            e = exp_q.pop_front();
            chk("bus", int'(bus), int'(e));
          end
        end
        if (lcd_rs) begin
          data_rises++;
          chars_in_frame++;
          last_data_rise = cyc;
        end
        prev_byte = bus;
        have_prev = 1'b1;
      end
      if (!lcd_en && pen) begin
        chk("en_high", cyc - rise_cyc, 2);
        fall_cyc = cyc;
      end
      if (frame_done) begin
        frames++;
        chk("fd_chars", chars_in_frame, 32);
        chk("fd_timing", cyc - last_data_rise, 5);
        chars_in_frame = 0;
        if (pfd) fail("fd_width");
      end
      if (pinit) chk("init_sticky", int'(init_done), 1);
      pen = lcd_en; pbus = bus; pfd = frame_done; pinit = init_done;
    end
  end

  // 40-entry instance monitor: first frame only
  logic [7:0] b_model [40];
  int b_rises = 0, b_chars = 0, b_frames = 0;
  bit b_pen = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_en && !b_pen) begin
        if (b_frames == 0) b_rises++;
        if (b_rs && b_frames == 0) begin
          if (b_chars < 40) chk("b_byte", int'(b_data), int'(b_model[b_chars]));
          b_chars++;
        end
      end
      if (b_frame_done) begin
        if (b_frames == 0) begin
          chk("b_chars", b_chars, 40);
          chk("b_rises", b_rises, 46);
        end
        b_frames++;
      end
      b_pen = b_en;
    end
  end

  wr_rec_t   wr_tbl [6];
  wr_rec_t   b_tbl [2];
  init_rec_t init_tbl [4];
  int n;

  task automatic push_init();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, init_tbl[i].cmd});
  endtask

  initial begin
    wr_tbl[0] = '{0, 8'h48, 1'b1};
    wr_tbl[1] = '{1, 8'h45, 1'b1};
    wr_tbl[2] = '{2, 8'h4C, 1'b1};
    wr_tbl[3] = '{3, 8'h4C, 1'b1};
    wr_tbl[4] = '{4, 8'h4F, 1'b1};
    wr_tbl[5] = '{16, 8'h57, 1'b1};
    b_tbl[0] = '{39, 8'h5A, 1'b1};
    b_tbl[1] = '{40, 8'h58, 1'b0};
    init_tbl[0] = '{8'h38, 4};
    init_tbl[1] = '{8'h0C, 4};
    init_tbl[2] = '{8'h01, 10};
    init_tbl[3] = '{8'h06, 4};
    for (int i = 0; i < 32; i++) model[i] = 8'h20;
    for (int i = 0; i < 40; i++) b_model[i] = 8'h20;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;

    repeat (3) @(negedge clk);
    chk("rst_en", int'(lcd_en), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_data", int'(lcd_data), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("lcd_on", int'(lcd_on), 1);
    chk("lcd_rw", int'(lcd_rw), 0);
    chk("lcd_blon", int'(lcd_blon), 1);

    push_init();
    chk_on = 1'b1;
    #2 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_addr = 5'(wr_tbl[i].addr);
      wr_data = wr_tbl[i].data;
      if (i < 2) begin
        b_wr_en = 1'b1;
        b_wr_addr = 6'(b_tbl[i].addr);
        b_wr_data = b_tbl[i].data;
        if (b_tbl[i].lands) b_model[b_tbl[i].addr] = b_tbl[i].data;
      end else b_wr_en = 1'b0;
      if (wr_tbl[i].lands) model[wr_tbl[i].addr] = wr_tbl[i].data;
    end
    @(negedge clk);
    wr_en = 1'b0;
    b_wr_en = 1'b0;

    push_frame();
    push_frame();
    model[3] = 8'h41;
    push_frame();

    n = 0;
    while (data_rises < 35 && n < 5000) begin @(posedge clk); n++; end
    if (n >= 5000) fail("timeout_char35");
    repeat (5) @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'h41;
    @(negedge clk);
    wr_en = 1'b0;

    n = 0;
    while (frames < 3 && n < 5000) begin @(posedge clk); n++; end
    if (n >= 5000) fail("timeout_frame3");
    chk("queue_drained", exp_q.size(), 0);
    chk("b_frame_seen", int'(b_frames >= 1), 1);
    chk_on = 1'b0;

    n = 0;
    while (!(lcd_en && lcd_rs) && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) fail("timeout_char_en");
    #2 rst_n = 1'b0;
    #1;
    chk("async_en", int'(lcd_en), 0);
    chk("async_init_done", int'(init_done), 0);
    chk("async_rs", int'(lcd_rs), 0);
    chk("async_data", int'(lcd_data), 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 32; i++) model[i] = 8'h20;
    push_init();
    push_frame();
    chk_on = 1'b1;
    #2 rst_n = 1'b1;

    n = 0;
    while (frames < 4 && n < 5000) begin @(posedge clk); n++; end
    if (n >= 5000) fail("timeout_frame4");
    chk("queue_drained2", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
